// File: rtl/blink_ctrl_if.sv
// Configuration write port of the blink controller: a single-entry write
// of one channel's on/off lengths, gated by cfg_ready.
interface blink_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             cfg_we;
    logic             cfg_sel;
    logic [WIDTH-1:0] cfg_on;
    logic [WIDTH-1:0] cfg_off;
    logic             cfg_ready;

    modport master (
        output cfg_we, cfg_sel, cfg_on, cfg_off,
        input  cfg_ready
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_on, cfg_off,
        output cfg_ready
    );
endinterface

// File: rtl/blink_ctrl.sv
// Cursor and character blink generator: two frame-counting on/off channels
// with a one-deep pending configuration register applied on the next frame.
module blink_ctrl #(
    parameter int WIDTH      = 8,
    parameter int CURSOR_ON  = 16,
    parameter int CURSOR_OFF = 16,
    parameter int CHAR_ON    = 32,
    parameter int CHAR_OFF   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        cursor_restart,
    blink_ctrl_if.slave cfg,
    output logic        cursor_blink,
    output logic        char_blink
);

    typedef struct packed {
        logic             is_on;
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] on_len;
        logic [WIDTH-1:0] off_len;
    } chan_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    localparam chan_t CUR_RST = '{is_on: 1'b1, cnt: '0,
                                  on_len: WIDTH'(CURSOR_ON), off_len: WIDTH'(CURSOR_OFF)};
    localparam chan_t CHR_RST = '{is_on: 1'b1, cnt: '0,
                                  on_len: WIDTH'(CHAR_ON), off_len: WIDTH'(CHAR_OFF)};

    chan_t            r_cur;
    chan_t            r_chr;
    logic             r_pend_valid;
    logic             r_pend_sel;
    logic [WIDTH-1:0] r_pend_on;
    logic [WIDTH-1:0] r_pend_off;

    chan_t            w_cur_nxt;
    chan_t            w_chr_nxt;
    logic             w_accept;
    logic             w_apply;

    // A zero on-length parks the channel dark; a zero off-length parks it lit
    // with the counter held at 0. Counters never exceed length-1, so no wrap.
    function automatic chan_t chan_tick(input chan_t c);
        chan_t n;
        n = c;
        if (c.on_len == '0) begin
            n = c;
        end else if (c.off_len == '0) begin
            n.cnt = '0;
        end else if (c.is_on) begin
            if (c.cnt == c.on_len - ONE) begin
                n.is_on = 1'b0;
                n.cnt   = '0;
            end else begin
                n.cnt = c.cnt + ONE;
            end
        end else begin
            if (c.cnt == c.off_len - ONE) begin
                n.is_on = 1'b1;
                n.cnt   = '0;
            end else begin
                n.cnt = c.cnt + ONE;
            end
        end
        return n;
    endfunction

    function automatic logic chan_out(input chan_t c);
        if (c.on_len == '0)
            return 1'b0;
        else if (c.off_len == '0)
            return 1'b1;
        else
            return c.is_on;
    endfunction

    assign w_accept = cfg.cfg_we && !r_pend_valid;
    assign w_apply  = frame_tick && r_pend_valid;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned, which would infer a latch.
        w_cur_nxt = r_cur;
        w_chr_nxt = r_chr;

        if (frame_tick) begin
            w_cur_nxt = chan_tick(r_cur);
            w_chr_nxt = chan_tick(r_chr);
        end

        // An apply replaces that channel's tick result instead of counting.
        if (w_apply) begin
            if (r_pend_sel) begin
                w_chr_nxt = '{is_on: 1'b1, cnt: '0, on_len: r_pend_on, off_len: r_pend_off};
            end else begin
                w_cur_nxt = '{is_on: 1'b1, cnt: '0, on_len: r_pend_on, off_len: r_pend_off};
            end
        end

        // Restart keeps whatever lengths are in effect, including a fresh apply.
        if (cursor_restart) begin
            w_cur_nxt.is_on = 1'b1;
            w_cur_nxt.cnt   = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur        <= CUR_RST;
            r_chr        <= CHR_RST;
            r_pend_valid <= 1'b0;
            r_pend_sel   <= 1'b0;
            r_pend_on    <= '0;
            r_pend_off   <= '0;
        end else begin
            r_cur <= w_cur_nxt;
            r_chr <= w_chr_nxt;
            if (w_accept) begin
                r_pend_valid <= 1'b1;
                r_pend_sel   <= cfg.cfg_sel;
                r_pend_on    <= cfg.cfg_on;
                r_pend_off   <= cfg.cfg_off;
            end else if (w_apply) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    assign cfg.cfg_ready = !r_pend_valid;
    assign cursor_blink  = chan_out(r_cur);
    assign char_blink    = chan_out(r_chr);

endmodule

// File: doc/blink_ctrl.md
BLINK_CTRL -- requirements
Module: blink_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the bit width of all length fields and frame counters.
REQ-002 The block SHALL have parameter CURSOR_ON, default 16, giving the reset cursor on-length in frames.
REQ-003 The block SHALL have parameter CURSOR_OFF, default 16, giving the reset cursor off-length in frames.
REQ-004 The block SHALL have parameter CHAR_ON, default 32, giving the reset character on-length in frames.
REQ-005 The block SHALL have parameter CHAR_OFF, default 32, giving the reset character off-length in frames.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port frame_tick, input, 1 bit: one-cycle pulse per video frame.
REQ-009 The block SHALL have port cursor_restart, input, 1 bit: pulse that forces the cursor channel visible.
REQ-010 The block SHALL have port cfg_we, input, 1 bit: configuration write strobe.
REQ-011 The block SHALL have port cfg_sel, input, 1 bit: target channel, 0 = cursor, 1 = character.
REQ-012 The block SHALL have port cfg_on, input, WIDTH bits: new on-length in frames.
REQ-013 The block SHALL have port cfg_off, input, WIDTH bits: new off-length in frames.
REQ-014 The block SHALL have port cfg_ready, output, 1 bit: high when a write can be accepted.
REQ-015 The block SHALL have port cursor_blink, output, 1 bit: cursor visible.
REQ-016 The block SHALL have port char_blink, output, 1 bit: blinking characters visible.

Function
REQ-017 The block SHALL contain two identical channels, cursor and character, each with state ON/OFF, a WIDTH-bit frame counter, and active on_len/off_len registers.
REQ-018 Counters SHALL advance only on cycles where frame_tick=1; other cycles SHALL hold all channel state.
REQ-019 In ON with on_len>0 and off_len>0, a tick SHALL go to OFF with counter 0 when counter==on_len-1, else increment the counter.
REQ-020 In OFF, a tick SHALL go to ON with counter 0 when counter==off_len-1, else increment the counter.
REQ-021 If on_len==0, the channel output SHALL be constant 0 regardless of off_len.
REQ-022 If on_len>0 and off_len==0, the channel output SHALL be constant 1 and the counter SHALL hold 0.
REQ-023 Otherwise each channel output SHALL be 1 exactly when its state is ON.
REQ-024 Outputs SHALL be driven from registered state only, with no combinational path from any input.
REQ-025 A cfg_we with cfg_ready=1 SHALL capture cfg_sel, cfg_on and cfg_off into a pending register and drive cfg_ready low on the next cycle.
REQ-026 A cfg_we with cfg_ready=0 SHALL be ignored, with no state change.
REQ-027 At the first frame_tick strictly after capture, the pending lengths SHALL load into the selected channel; that channel SHALL restart at ON with counter 0, and the tick SHALL NOT also count.
REQ-028 cfg_ready SHALL return high on the cycle after that apply tick.
REQ-029 A cfg_we and frame_tick in the same cycle with cfg_ready=1 SHALL capture only; the apply SHALL occur at the following tick.
REQ-030 cursor_restart SHALL set the cursor channel to ON with counter 0 on the next edge, overriding any tick count in that cycle.
REQ-031 A cursor_restart coinciding with a pending cursor apply SHALL still apply the new lengths, leaving state ON with counter 0.
REQ-032 The unselected channel SHALL be unaffected by applies and by cursor_restart.
REQ-033 Counter comparisons SHALL use full WIDTH; on_len or off_len of 2^WIDTH-1 SHALL be legal, and no counter SHALL wrap past its length.

Reset
REQ-034 When reset=1 at a clock edge, both channels SHALL go to ON with counter 0, active lengths SHALL take their parameter defaults, the pending write SHALL be discarded, and cfg_ready SHALL be 1.
REQ-035 After reset, cursor_blink SHALL equal (CURSOR_ON!=0) and char_blink SHALL equal (CHAR_ON!=0).
REQ-036 Reset SHALL override frame_tick, cfg_we and cursor_restart in the same cycle.

Verification
REQ-037 With CURSOR_ON=3, CURSOR_OFF=2 and reset then 10 ticks, cursor_blink after each tick SHALL read 1,1,0,0,1,1,1,0,0,1 (initial value 1).
REQ-038 Write sel=1, on=1, off=1 with ticks 4 cycles apart: cfg_ready=0 until the first tick, char_blink=1 after it, then alternates 0,1 per tick, and cfg_ready=1 the cycle after apply.
REQ-039 Issue a second cfg_we while cfg_ready=0: it SHALL be ignored, and only the first write's lengths SHALL be applied.
REQ-040 Write cursor on=0, off=5: cursor_blink SHALL be 0 from the apply onward; then write on=4, off=0: cursor_blink SHALL be constant 1.
REQ-041 During cursor OFF, assert cursor_restart together with frame_tick: cursor_blink SHALL be 1 next cycle, and the OFF transition SHALL occur after CURSOR_ON further ticks.
REQ-042 Assert reset mid-pending-write coincident with cfg_we: cfg_ready SHALL be 1, lengths SHALL be the defaults, and no later apply SHALL occur.
